mem_port_arbiter: RTL and testbench

// - Sits directly downstream of cpu: merges its instruction port (inst_*) and data port (data_*) onto one word-wide physical memory port (pmem_*).
// - Serves one transaction at a time. Data has priority, with a bounded-starvation guarantee for fetch.
// - A watchdog flags a memory that never responds.

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter.sv | 117 +++++++++++
 tb/tb_mem_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the CPU-side memory port arbiter: the machine word,
// the arbiter state encoding and the latched physical-memory request record.
package rv32i_types;
  typedef logic [31:0] rv32i_word;
endpackage

package arb_types;
  import rv32i_types::*;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INST = 2'd1,
    DATA = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic       read;
    logic       write;
    logic [3:0] mbe;
    rv32i_word  addr;
    rv32i_word  wdata;
  } pmem_req_t;

  localparam logic [3:0] MBE_FULL = 4'hF;
endpackage

// File: rtl/mem_port_arbiter.sv
// Merges the CPU fetch and load/store ports onto one physical memory port:
// data-first, with a bounded fetch-starvation streak and a sticky watchdog.
//   state | meaning
//   IDLE  | nothing in flight; grant decision made every cycle
//   INST  | fetch on pmem, waiting for pmem_resp
//   DATA  | load/store on pmem, waiting for pmem_resp
module mem_port_arbiter
  import rv32i_types::*;
  import arb_types::*;
#(
  parameter int unsigned DATA_STREAK_MAX = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inst_read,
  input  rv32i_word  inst_addr,
  output logic       inst_resp,
  output rv32i_word  inst_rdata,
  input  logic       data_read,
  input  logic       data_write,
  input  logic [3:0] data_mbe,
  input  rv32i_word  data_addr,
  input  rv32i_word  data_wdata,
  output logic       data_resp,
  output rv32i_word  data_rdata,
  output logic       pmem_read,
  output logic       pmem_write,
  output logic [3:0] pmem_mbe,
  output rv32i_word  pmem_addr,
  output rv32i_word  pmem_wdata,
  input  logic       pmem_resp,
  input  rv32i_word  pmem_rdata,
  output logic       timeout_err
);
  localparam int unsigned SW = $clog2(DATA_STREAK_MAX + 1);
  localparam int unsigned WW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] STREAK_MAX = SW'(DATA_STREAK_MAX);
  localparam logic [WW-1:0] WD_LAST = WW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

  arb_state_t    state_q, state_d;
  pmem_req_t     req_q, req_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [WW-1:0] wd_q, wd_d;
  logic          err_q;
  logic          busy, data_pend, wd_hit;

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    streak_d   = streak_q;
    wd_d       = '0;
    inst_resp  = 1'b0;
    data_resp  = 1'b0;
    inst_rdata = '0;
    data_rdata = '0;
    busy       = (state_q != IDLE);
    data_pend  = data_read | data_write;
    // wd_q holds completed busy cycles, so the last allowed one is flagged live
    wd_hit     = WD_EN && busy && !pmem_resp && (wd_q == WD_LAST);
    unique case (state_q)
      IDLE: begin
        if (data_pend && !(inst_read && streak_q == STREAK_MAX)) begin
          state_d = DATA;
          req_d   = '{read: data_read & ~data_write, write: data_write,
                      mbe: data_mbe, addr: data_addr, wdata: data_wdata};
          if (inst_read) streak_d = streak_q + 1'b1;
        end else if (inst_read) begin
          state_d  = INST;
          req_d    = '{read: 1'b1, write: 1'b0, mbe: MBE_FULL, addr: inst_addr, wdata: '0};
          streak_d = '0;
        end
      end
      INST, DATA: begin
        if (pmem_resp) begin
          state_d     = IDLE;
          req_d.read  = 1'b0;
          req_d.write = 1'b0;
          if (state_q == INST) begin
            inst_resp  = 1'b1;
            inst_rdata = pmem_rdata;
          end else begin
            data_resp  = 1'b1;
            data_rdata = pmem_rdata;
          end
        end else begin
          wd_d = (wd_q == WD_LAST) ? wd_q : wd_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      req_q    <= '0;
      streak_q <= '0;
      wd_q     <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      streak_q <= streak_d;
      wd_q     <= wd_d;
      err_q    <= err_q | wd_hit;
    end
  end

  assign pmem_read   = req_q.read;
  assign pmem_write  = req_q.write;
  assign pmem_mbe    = req_q.mbe;
  assign pmem_addr   = req_q.addr;
  assign pmem_wdata  = req_q.wdata;
  assign timeout_err = err_q | wd_hit;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized
// CPU/memory traffic compared against a transaction-level arbitration model.
module tb_mem_port_arbiter;
  import rv32i_types::*;

  localparam int STREAK = 4;
  localparam int TMO    = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       inst_read, inst_resp, data_read, data_write, data_resp;
  logic       pmem_read, pmem_write, pmem_resp, timeout_err;
  logic [3:0] data_mbe, pmem_mbe;
  rv32i_word  inst_addr, inst_rdata, data_addr, data_wdata, data_rdata;
  rv32i_word  pmem_addr, pmem_wdata, pmem_rdata;

  int checks = 0;
  int failures = 0;

  bit        ipend, dpend, m_busy, e_rd, e_wr, exp_inst, ir, dr;
  int        m_owner, m_streak, mwait, dk, grants, d_done;
  rv32i_word ia, da, dw, e_addr, e_wdata;
  logic [3:0] dm, e_mbe;

  always #5 clk = ~clk;

  mem_port_arbiter #(.DATA_STREAK_MAX(STREAK), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .inst_read(inst_read), .inst_addr(inst_addr), .inst_resp(inst_resp), .inst_rdata(inst_rdata),
    .data_read(data_read), .data_write(data_write), .data_mbe(data_mbe), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_resp(data_resp), .data_rdata(data_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_mbe(pmem_mbe), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .timeout_err(timeout_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_read = 0; inst_addr = '0;
    data_read = 0; data_write = 0; data_mbe = '0; data_addr = '0; data_wdata = '0;
    pmem_resp = 0; pmem_rdata = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pmem_read"},  pmem_read, 0);
    check({tag, "_pmem_write"}, pmem_write, 0);
    check({tag, "_pmem_addr"},  pmem_addr, 0);
    check({tag, "_pmem_mbe"},   pmem_mbe, 0);
    check({tag, "_pmem_wdata"}, pmem_wdata, 0);
    check({tag, "_inst_resp"},  inst_resp, 0);
    check({tag, "_inst_rdata"}, inst_rdata, 0);
    check({tag, "_data_resp"},  data_resp, 0);
    check({tag, "_data_rdata"}, data_rdata, 0);
    check({tag, "_timeout"},    timeout_err, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_time_limit observed=expired required=finish");
    $fatal(1, "time limit");
  end

  initial begin
    idle_inputs();
    // requests and a memory response while reset is held must produce nothing
    inst_read = 1; data_write = 1; pmem_resp = 1; pmem_rdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1;
    idle_inputs();
    next_cycle();

    // lone fetch, memory answers on the third busy cycle
    inst_read = 1; inst_addr = 32'h60;
    @(negedge clk);
    check("fetch_no_early_strobe", pmem_read, 0);
    next_cycle();
    for (int c = 1; c <= 4; c++) begin
      pmem_resp  = (c == 3);
      pmem_rdata = (c == 3) ? 32'h00A0_0093 : 32'h1234_5678;
      if (c == 4) inst_read = 0;
      @(negedge clk);
      check("fetch_pmem_read", pmem_read, c <= 3);
      check("fetch_pmem_write", pmem_write, 0);
      if (c <= 3) begin
        check("fetch_addr", pmem_addr, 32'h60);
        check("fetch_mbe", pmem_mbe, 4'hF);
      end
      check("fetch_inst_resp", inst_resp, c == 3);
      check("fetch_inst_rdata", inst_rdata, (c == 3) ? 32'h00A0_0093 : 32'h0);
      check("fetch_no_data_resp", data_resp, 0);
      next_cycle();
    end

    // store with partial byte enables
    data_write = 1; data_addr = 32'h100; data_wdata = 32'hDEAD_BEEF; data_mbe = 4'b0011;
    @(negedge clk);
    check("store_no_early_strobe", pmem_write, 0);
    next_cycle();
    for (int c = 1; c <= 4; c++) begin
      pmem_resp  = (c == 3);
      pmem_rdata = (c == 3) ? 32'hCAFE_0000 : 32'h0BAD_F00D;
      if (c == 4) data_write = 0;
      @(negedge clk);
      check("store_pmem_write", pmem_write, c <= 3);
      check("store_pmem_read", pmem_read, 0);
      if (c <= 3) begin
        check("store_addr", pmem_addr, 32'h100);
        check("store_wdata", pmem_wdata, 32'hDEAD_BEEF);
        check("store_mbe", pmem_mbe, 4'b0011);
      end
      check("store_data_resp", data_resp, c == 3);
      check("store_data_rdata", data_rdata, (c == 3) ? 32'hCAFE_0000 : 32'h0);
      check("store_no_inst_resp", inst_resp, 0);
      next_cycle();
    end

    // simultaneous fetch and load: data first, fetch after one idle cycle
    inst_read = 1; inst_addr = 32'h64; data_read = 1; data_addr = 32'h200;
    next_cycle();
    pmem_resp = 1; pmem_rdata = 32'h1111_1111;
    @(negedge clk);
    check("simul_first_read", pmem_read, 1);
    check("simul_first_addr", pmem_addr, 32'h200);
    check("simul_data_resp", data_resp, 1);
    check("simul_data_rdata", data_rdata, 32'h1111_1111);
    check("simul_inst_waits", inst_resp, 0);
    next_cycle();
    data_read = 0; pmem_resp = 0;
    @(negedge clk);
    check("simul_idle_gap", pmem_read, 0);
    next_cycle();
    pmem_resp = 1; pmem_rdata = 32'h2222_2222;
    @(negedge clk);
    check("simul_second_addr", pmem_addr, 32'h64);
    check("simul_second_mbe", pmem_mbe, 4'hF);
    check("simul_inst_resp", inst_resp, 1);
    check("simul_inst_rdata", inst_rdata, 32'h2222_2222);
    check("simul_no_data_resp", data_resp, 0);
    next_cycle();
    inst_read = 0; pmem_resp = 0;
    next_cycle();

    // fetch held while ten loads arrive back to back: every fifth grant is the fetch
    inst_read = 1; inst_addr = 32'h80; data_read = 1; d_done = 0; grants = 0;
    for (int cyc = 0; cyc < 100 && d_done < 10; cyc++) begin
      data_addr  = 32'h1000 + 32'(4 * d_done);
      pmem_resp  = pmem_read | pmem_write;
      pmem_rdata = $urandom;
      @(negedge clk);
      if (pmem_read) begin
        exp_inst = ((grants % (STREAK + 1)) == STREAK);
        check("streak_owner_addr", pmem_addr, exp_inst ? 32'h80 : 32'h1000 + 32'(4 * d_done));
        check("streak_inst_resp", inst_resp, exp_inst);
        check("streak_data_resp", data_resp, !exp_inst);
        grants++;
        if (!exp_inst) d_done++;
      end
      next_cycle();
    end
    check("streak_data_done", d_done, 10);
    check("streak_grants", grants, 12);
    inst_read = 0; data_read = 0; pmem_resp = 0;
    next_cycle();

    // memory never answers: flag on the TMO-th busy cycle, sticky, then reset mid-transaction
    inst_read = 1; inst_addr = 32'h40;
    next_cycle();
    for (int k = 1; k <= TMO + 3; k++) begin
      @(negedge clk);
      check("wdog_flag", timeout_err, k >= TMO);
      check("wdog_strobe_held", pmem_read, 1);
      check("wdog_no_resp", inst_resp, 0);
      next_cycle();
    end
    #2 rst = 0;
    #1 pmem_resp = 1; pmem_rdata = 32'h5555_5555;
    #1;
    check_all_zero("midrst");
    @(posedge clk);
    #1;
    check("midrst_hold_resp", inst_resp, 0);
    check("midrst_hold_read", pmem_read, 0);
    @(negedge clk);
    rst = 1;
    idle_inputs();
    next_cycle();
    @(negedge clk);
    check("postrst_idle_read", pmem_read, 0);
    check("postrst_timeout", timeout_err, 0);
    next_cycle();

    // randomized traffic against the arbitration model
    ipend = 0; dpend = 0; m_busy = 0; m_owner = 0; m_streak = 0; mwait = 0;
    e_rd = 0; e_wr = 0; e_addr = '0; e_wdata = '0; e_mbe = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!ipend && $urandom_range(0, 2) == 0) begin
        ipend = 1; ia = $urandom & 32'hFFFF_FFFC;
      end
      if (!dpend && $urandom_range(0, 2) == 0) begin
        dpend = 1; dk = int'($urandom_range(0, 2));
        da = $urandom; dw = $urandom; dm = 4'($urandom_range(0, 15));
      end
      inst_read  = ipend;
      inst_addr  = ipend ? ia : $urandom;
      data_read  = dpend && (dk != 1);
      data_write = dpend && (dk != 0);
      data_addr  = dpend ? da : $urandom;
      data_wdata = dpend ? dw : $urandom;
      data_mbe   = dpend ? dm : 4'($urandom_range(0, 15));
      pmem_rdata = $urandom;
      if (m_busy && mwait == 0) pmem_resp = 1;
      else begin
        pmem_resp = 0;
        if (m_busy) mwait--;
      end
      @(negedge clk);
      ir = m_busy && (m_owner == 0) && pmem_resp;
      dr = m_busy && (m_owner == 1) && pmem_resp;
      check("rnd_pmem_read", pmem_read, m_busy && e_rd);
      check("rnd_pmem_write", pmem_write, m_busy && e_wr);
      if (m_busy) begin
        check("rnd_pmem_addr", pmem_addr, e_addr);
        check("rnd_pmem_mbe", pmem_mbe, e_mbe);
        if (e_wr) check("rnd_pmem_wdata", pmem_wdata, e_wdata);
      end
      check("rnd_inst_resp", inst_resp, ir);
      check("rnd_inst_rdata", inst_rdata, ir ? pmem_rdata : 32'h0);
      check("rnd_data_resp", data_resp, dr);
      check("rnd_data_rdata", data_rdata, dr ? pmem_rdata : 32'h0);
      check("rnd_timeout", timeout_err, 0);
      if (m_busy) begin
        if (pmem_resp) begin
          m_busy = 0;
          if (m_owner == 0) ipend = 0;
          else dpend = 0;
        end
      end else if (dpend && !(ipend && m_streak == STREAK)) begin
        m_busy = 1; m_owner = 1; m_streak += int'(ipend);
        e_rd = (dk == 0); e_wr = (dk != 0); e_addr = da; e_mbe = dm; e_wdata = dw;
        mwait = int'($urandom_range(0, 4));
      end else if (ipend) begin
        m_busy = 1; m_owner = 0; m_streak = 0;
        e_rd = 1; e_wr = 0; e_addr = ia; e_mbe = 4'hF;
        mwait = int'($urandom_range(0, 4));
      end
      next_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
